// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle for the sequential binary-to-BCD converter
interface bin2bcd_seq_if;
    logic         start;
    logic [127:0] bin;
    logic         busy;
    logic         done;
    logic [155:0] bcd;
    logic [5:0]   ndigits;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ndigits
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ndigits
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - 128-bit binary to 39-digit BCD, double-dabble one bit per cycle
// Optional macro BIN2BCD_SKIP_ZERO_BYTES_EN: skip leading all-zero operand bytes to shorten latency.
module bin2bcd_seq (
    input  logic          clock,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state_q;
    logic [127:0]   sh_q;
    logic [155:0]   acc_q;
    logic [7:0]     cnt_q;
    logic [155:0]   bcd_q;
    logic [5:0]     ndig_q;
    logic           busy_q;
    logic           done_q;

    logic [155:0]   acc_adj;
    logic [155:0]   acc_d;
    logic [127:0]   sh_d;
    logic [5:0]     ndig_d;
    logic [127:0]   load_sh;
    logic [7:0]     load_n;

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 39; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_d = {acc_adj[154:0], sh_q[127]};
        sh_d  = {sh_q[126:0], 1'b0};
        // Highest nonzero digit wins; an all-zero result still reports one digit.
        ndig_d = 6'd1;
        for (int i = 0; i < 39; i++) begin
            if (acc_d[4*i +: 4] != 4'd0) begin
                ndig_d = 6'(i + 1);
            end
        end
    end

`ifdef BIN2BCD_SKIP_ZERO_BYTES_EN
    logic [4:0] lz_bytes;
    logic       lz_found;

    always_comb begin
        lz_bytes = 5'd0;
        lz_found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!lz_found) begin
                if (bus.bin[8*i +: 8] == 8'd0) begin
                    lz_bytes = lz_bytes + 5'd1;
                end else begin
                    lz_found = 1'b1;
                end
            end
        end
        load_sh = bus.bin << {lz_bytes, 3'b000};
        load_n  = 8'd128 - {lz_bytes, 3'b000};
    end
`else
    always_comb begin
        load_sh = bus.bin;
        load_n  = 8'd128;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ndig_q  <= 6'd1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sh_q   <= load_sh;
                        acc_q  <= '0;
                        cnt_q  <= load_n;
                        busy_q <= 1'b1;
`ifdef BIN2BCD_SKIP_ZERO_BYTES_EN
                        if (load_n == 8'd0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            bcd_q   <= '0;
                            ndig_q  <= 6'd1;
                        end else
`endif
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - 8'd1;
                    // Results are published only on the final iteration edge.
                    if (cnt_q == 8'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        bcd_q   <= acc_d;
                        ndig_q  <= ndig_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd     = bcd_q;
    assign bus.ndigits = ndig_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed and exponent-chained checks for bin2bcd_seq
module tb_bin2bcd_seq;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    bin2bcd_seq_if u_if ();

    bin2bcd_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lat(input int off_n, input int on_n);
`ifdef BIN2BCD_SKIP_ZERO_BYTES_EN
        return on_n;
`else
        return off_n;
`endif
    endfunction

    task automatic chk(input string tag, input logic [155:0] obs, input logic [155:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_conv(input logic [127:0] v);
        @(negedge clock);
        u_if.start = 1'b1;
        u_if.bin   = v;
        @(posedge clock);
        #1;
        u_if.start = 1'b0;
        u_if.bin   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!u_if.done && edges < 400) begin
            @(posedge clock);
            #1;
            edges++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [127:0] v, input logic [155:0] exp_bcd,
                           input logic [5:0] exp_nd, input int exp_lat);
        int edges;
        start_conv(v);
        chk({tag, "_busy"}, 156'(u_if.busy), 156'(1));
        wait_done(edges);
        chk({tag, "_lat"}, 156'(edges), 156'(exp_lat));
        chk({tag, "_bcd"}, u_if.bcd, exp_bcd);
        chk({tag, "_nd"}, 156'(u_if.ndigits), 156'(exp_nd));
        @(posedge clock);
        #1;
        chk({tag, "_done_drop"}, 156'({u_if.done, u_if.busy}), 156'(0));
    endtask

    initial begin
        int            edges;
        int            pulses;
        int            x;
        int            y;
        logic [127:0]  ref_v;
        logic [127:0]  dec_v;
        logic [127:0]  t;
        logic [5:0]    ref_nd;
        logic          dig_ok;

        total = 0;
        bad   = 0;
        u_if.start = 1'b0;
        u_if.bin   = '0;
        reset      = 1'b0;
        #12;
        chk("rst_busy", 156'(u_if.busy), 156'(0));
        chk("rst_done", 156'(u_if.done), 156'(0));
        chk("rst_bcd", u_if.bcd, 156'(0));
        chk("rst_nd", 156'(u_if.ndigits), 156'(1));
        @(negedge clock);
        reset = 1'b1;

        run_vec("zero", 128'd0, 156'h0, 6'd1, lat(128, 0));
        run_vec("k1000", 128'd1000, 156'h1000, 6'd4, lat(128, 16));
        run_vec("max", 128'd340282366920938463463374607431768211455,
                156'h340282366920938463463374607431768211455, 6'd39, lat(128, 128));
        run_vec("n99", 128'd99, 156'h99, 6'd2, lat(128, 8));
        run_vec("n20dig", 128'd12345678901234567890, 156'h12345678901234567890, 6'd20, lat(128, 64));
        run_vec("e38", 128'd100000000000000000000000000000000000000,
                156'h100000000000000000000000000000000000000, 6'd39, lat(128, 128));

        // Second start mid-conversion must be ignored without queueing.
        start_conv(128'd1000);
        repeat (9) @(posedge clock);
        @(negedge clock);
        u_if.start = 1'b1;
        u_if.bin   = 128'd555;
        @(posedge clock);
        #1;
        u_if.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (u_if.done) pulses++;
        end
        chk("ign_pulses", 156'(pulses), 156'(1));
        chk("ign_bcd", u_if.bcd, 156'h1000);
        chk("ign_nd", 156'(u_if.ndigits), 156'(4));

        // Reset mid-conversion aborts with no done pulse.
        start_conv(128'd340282366920938463463374607431768211455);
        repeat (60) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 156'(u_if.busy), 156'(0));
        chk("abort_done", 156'(u_if.done), 156'(0));
        chk("abort_bcd", u_if.bcd, 156'(0));
        chk("abort_nd", 156'(u_if.ndigits), 156'(1));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clock);
            #1;
            if (u_if.done || u_if.busy) pulses++;
        end
        chk("abort_quiet", 156'(pulses), 156'(0));
        run_vec("after_rst", 128'd1000, 156'h1000, 6'd4, lat(128, 16));

        // Chained exponent results: decode the BCD back to binary and compare to X**Y.
        for (int k = 0; k < 100; k++) begin
            x = int'($urandom_range(1000, 2));
            y = int'($urandom_range(12, 0));
            ref_v = 128'd1;
            for (int j = 0; j < y; j++) ref_v = ref_v * 128'(x);
            ref_nd = 6'd1;
            t = ref_v / 128'd10;
            while (t != 128'd0) begin
                ref_nd = ref_nd + 6'd1;
                t = t / 128'd10;
            end
            start_conv(ref_v);
            wait_done(edges);
            dec_v  = '0;
            dig_ok = 1'b1;
            for (int d = 38; d >= 0; d--) begin
                if (u_if.bcd[4*d +: 4] > 4'd9) dig_ok = 1'b0;
                dec_v = dec_v * 128'd10 + 128'(u_if.bcd[4*d +: 4]);
            end
            chk("expo_val", 156'(dec_v), 156'(ref_v));
            chk("expo_nd", 156'(u_if.ndigits), 156'(ref_nd));
            chk("expo_digits", 156'(dig_ok), 156'(1));
            @(posedge clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
